// File: rtl/cp_command_scheduler_pkg.sv
// Shared CBC message layout, VP command opcodes and scheduler state encoding.
// Optional statistics are enabled with the CP_SCHED_STATS_EN macro in cp_command_scheduler.
package cp_command_scheduler_pkg;

  localparam int CBC_BUS_WIDTH       = 16;
  localparam int VPID_WIDTH          = 6;
  localparam int MSG_VALID           = 15;
  localparam int CP_MSG_BCAST        = 14;
  localparam int CP_MSG_DST_HI       = 13;
  localparam int CP_MSG_DST_LO       = 8;
  localparam int CP_MSG_OPERATION_HI = 7;
  localparam int CP_MSG_OPERATION_LO = 4;
  localparam int CP_MSG_ARG_HI       = 3;
  localparam int CP_MSG_ARG_LO       = 0;

  localparam logic [3:0] VP_COMMAND_NOP               = 4'h0;
  localparam logic [3:0] VP_COMMAND_START_MAIN_THREAD = 4'h1;
  localparam logic [3:0] VP_COMMAND_STOP_MAIN_THREAD  = 4'h2;
  localparam logic [3:0] VP_COMMAND_SET_ARG           = 4'h3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_ISSUE = 2'd2,
    S_GAP   = 2'd3
  } sched_state_t;

  function automatic logic [VPID_WIDTH-1:0] msg_dst(input logic [CBC_BUS_WIDTH-1:0] m);
    return m[CP_MSG_DST_HI:CP_MSG_DST_LO];
  endfunction

  function automatic logic [3:0] msg_op(input logic [CBC_BUS_WIDTH-1:0] m);
    return m[CP_MSG_OPERATION_HI:CP_MSG_OPERATION_LO];
  endfunction

endpackage

// File: rtl/cp_command_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requesting index at or after i_ptr, wrapping.
module cp_command_scheduler_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [IW-1:0] o_idx,
  output logic          o_found
);

  always_comb begin
    int d;
    int best;
    o_idx   = '0;
    o_found = 1'b0;
    best    = N;
    for (int j = 0; j < N; j++) begin
      // Distance from the pointer going forward; smallest distance wins.
      d = j - int'(i_ptr);
      if (d < 0) d = d + N;
      if (i_req[j] && d < best) begin
        best    = d;
        o_idx   = IW'(j);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp_command_scheduler.sv
// Round-robin CBC command scheduler with per-VP busy backpressure and VP run-state shadow.
// Define CP_SCHED_STATS_EN to add saturating issue/drop counters (oIssueCount, oDropCount).
module cp_command_scheduler
  import cp_command_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int NUM_VP  = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                             Clock,
  input  logic                             Reset,
  input  logic [NUM_REQ-1:0]               iReq,
  input  logic [NUM_REQ*CBC_BUS_WIDTH-1:0] iReqMsg,
  output logic [NUM_REQ-1:0]               oGrant,
  output logic                             oReqErr,
  input  logic [NUM_VP-1:0]                iVpBusy,
  output logic [CBC_BUS_WIDTH-1:0]         oCpCommand,
  output logic [NUM_VP-1:0]                oVpRunning,
  output logic [1:0]                       oDbgState
`ifdef CP_SCHED_STATS_EN
  ,
  output logic [15:0]                      oIssueCount,
  output logic [15:0]                      oDropCount
`endif
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT);

  sched_state_t             r_state;
  logic [IW-1:0]            r_ptr;
  logic [IW-1:0]            r_win;
  logic [CBC_BUS_WIDTH-1:0] r_msg;
  logic [CW-1:0]            r_cnt;
  logic [CBC_BUS_WIDTH-1:0] r_cmd;
  logic [NUM_REQ-1:0]       r_grant;
  logic                     r_err;
  logic [NUM_VP-1:0]        r_running;

  logic [NUM_REQ-1:0]       w_req;
  logic [IW-1:0]            w_idx;
  logic                     w_found;
  logic [CBC_BUS_WIDTH-1:0] w_sel_msg;
  logic [VPID_WIDTH-1:0]    w_dst;
  logic                     w_bcast;
  logic                     w_dst_bad;
  logic                     w_dst_busy;
  logic                     w_ready;
  logic                     w_cnt_last;
  logic                     w_drop;
  logic [NUM_VP-1:0]        w_vp_mask;
  logic [NUM_VP-1:0]        w_run_next;
  logic [NUM_REQ-1:0]       w_win_oh;
  logic [IW-1:0]            w_win_inc;

  // A requester whose grant is showing this cycle is consuming its message; keep it out.
  assign w_req = iReq & ~r_grant;

  cp_command_scheduler_rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_arb (
    .i_req   (w_req),
    .i_ptr   (r_ptr),
    .o_idx   (w_idx),
    .o_found (w_found)
  );

  always_comb begin
    w_sel_msg = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (int'(w_idx) == k) w_sel_msg = iReqMsg[k*CBC_BUS_WIDTH +: CBC_BUS_WIDTH];
    end
  end

  assign w_dst     = msg_dst(r_msg);
  assign w_bcast   = r_msg[CP_MSG_BCAST];
  assign w_dst_bad = !w_bcast && (int'(w_dst) >= NUM_VP);

  always_comb begin
    w_dst_busy = 1'b0;
    w_vp_mask  = '0;
    for (int v = 0; v < NUM_VP; v++) begin
      if (int'(w_dst) == v) w_dst_busy = iVpBusy[v];
      if (w_bcast || int'(w_dst) == v) w_vp_mask[v] = 1'b1;
    end
  end

  assign w_ready    = w_bcast ? (iVpBusy == '0) : !w_dst_busy;
  assign w_cnt_last = (int'(r_cnt) == TIMEOUT - 1);
  assign w_drop     = (r_state == S_CHECK) && (w_dst_bad || (!w_ready && w_cnt_last));

  always_comb begin
    w_run_next = r_running;
    if (msg_op(r_msg) == VP_COMMAND_START_MAIN_THREAD) w_run_next = r_running | w_vp_mask;
    else if (msg_op(r_msg) == VP_COMMAND_STOP_MAIN_THREAD) w_run_next = r_running & ~w_vp_mask;
  end

  always_comb begin
    w_win_oh = '0;
    for (int k = 0; k < NUM_REQ; k++) w_win_oh[k] = (int'(r_win) == k);
  end

  assign w_win_inc = (int'(r_win) == NUM_REQ - 1) ? '0 : r_win + IW'(1);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_win     <= '0;
      r_msg     <= '0;
      r_cnt     <= '0;
      r_cmd     <= '0;
      r_grant   <= '0;
      r_err     <= 1'b0;
      r_running <= '0;
    end else begin
      r_cmd   <= '0;
      r_grant <= '0;
      r_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_win   <= w_idx;
            r_msg   <= w_sel_msg;
            r_cnt   <= '0;
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_drop) begin
            r_grant <= w_win_oh;
            r_err   <= 1'b1;
            r_ptr   <= w_win_inc;
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else if (w_ready) begin
            r_cmd            <= r_msg;
            r_cmd[MSG_VALID] <= 1'b1;
            r_grant          <= w_win_oh;
            r_cnt            <= '0;
            r_state          <= S_ISSUE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_ISSUE: begin
          r_ptr     <= w_win_inc;
          r_running <= w_run_next;
          r_state   <= S_GAP;
        end
        // Bus stays idle one cycle so the VP busy flag reflects the write just made.
        S_GAP: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign oCpCommand = r_cmd;
  assign oGrant     = r_grant;
  assign oReqErr    = r_err;
  assign oVpRunning = r_running;
  assign oDbgState  = r_state;

`ifdef CP_SCHED_STATS_EN
  logic [15:0] r_issue_cnt;
  logic [15:0] r_drop_cnt;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_issue_cnt <= '0;
      r_drop_cnt  <= '0;
    end else begin
      if (r_state == S_ISSUE && r_issue_cnt != 16'hFFFF) r_issue_cnt <= r_issue_cnt + 16'd1;
      if (w_drop && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign oIssueCount = r_issue_cnt;
  assign oDropCount  = r_drop_cnt;
`else
  // No statistics in this build.
`endif

endmodule

// File: tb/tb_cp_command_scheduler.sv
// Directed plus randomized bench for cp_command_scheduler against a cycle-timed behavioural model.
// Build with CP_SCHED_STATS_EN defined to also check the issue/drop counters.
module tb_cp_command_scheduler;
  import cp_command_scheduler_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int NUM_VP  = 4;
  localparam int TIMEOUT = 64;
  localparam int W       = 16;

  logic                   Clock;
  logic                   Reset;
  logic [NUM_REQ-1:0]     iReq;
  logic [NUM_REQ*W-1:0]   iReqMsg;
  logic [NUM_REQ-1:0]     oGrant;
  logic                   oReqErr;
  logic [NUM_VP-1:0]      iVpBusy;
  logic [W-1:0]           oCpCommand;
  logic [NUM_VP-1:0]      oVpRunning;
  logic [1:0]             oDbgState;
`ifdef CP_SCHED_STATS_EN
  logic [15:0]            oIssueCount;
  logic [15:0]            oDropCount;
`endif

  cp_command_scheduler #(
    .NUM_REQ (NUM_REQ),
    .NUM_VP  (NUM_VP),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .iReq       (iReq),
    .iReqMsg    (iReqMsg),
    .oGrant     (oGrant),
    .oReqErr    (oReqErr),
    .iVpBusy    (iVpBusy),
    .oCpCommand (oCpCommand),
    .oVpRunning (oVpRunning),
    .oDbgState  (oDbgState)
`ifdef CP_SCHED_STATS_EN
    ,
    .oIssueCount (oIssueCount),
    .oDropCount  (oDropCount)
`endif
  );

  // Clock / watchdog
  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Requester side
  logic [NUM_REQ-1:0] pend;
  logic [W-1:0]       pend_msg  [NUM_REQ];
  logic [NUM_REQ-1:0] stage;
  logic [W-1:0]       stage_msg [NUM_REQ];

  // Reference model: arbitration time, check-window start, when the bus is free again
  bit                 m_wait;
  int                 m_ptr, m_win, m_chk_start, m_free_at, m_run_at;
  int                 m_issues, m_drops;
  logic [W-1:0]       m_msg;
  logic [NUM_VP-1:0]  m_run, m_run_next;
  logic [W-1:0]       e_cmd;
  logic [NUM_REQ-1:0] e_grant;
  logic               e_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [W-1:0] mk_msg(input bit v, input bit bc, input int dst,
                                          input logic [3:0] op, input logic [3:0] arg);
    logic [5:0] d;
    d = 6'(dst);
    return {v, bc, d, op, arg};
  endfunction

  task automatic post(input int k, input logic [W-1:0] msg);
    stage[k]     = 1'b1;
    stage_msg[k] = msg;
  endtask

  task automatic drive();
    iReq = pend;
    for (int k = 0; k < NUM_REQ; k++) iReqMsg[k*W +: W] = pend_msg[k];
  endtask

  task automatic model_reset();
    m_wait = 0; m_ptr = 0; m_win = 0; m_chk_start = 0; m_free_at = cyc; m_run_at = -1;
    m_issues = 0; m_drops = 0;
    m_msg = '0; m_run = '0; m_run_next = '0;
    e_cmd = '0; e_grant = '0; e_err = 1'b0;
  endtask

  // Predicts the outputs visible one cycle later from the inputs just driven.
  task automatic model_step();
    int dst, k;
    bit bc, ready, drop;
    logic [NUM_VP-1:0] tgt;
    e_cmd = '0; e_grant = '0; e_err = 1'b0;
    if (m_wait) begin
      dst   = int'(m_msg[13:8]);
      bc    = m_msg[14];
      ready = bc ? (iVpBusy == '0) : (dst < NUM_VP && iVpBusy[dst] == 1'b0);
      drop  = (!bc && dst >= NUM_VP) || (!ready && (cyc - m_chk_start) == TIMEOUT - 1);
      if (drop) begin
        e_grant   = NUM_REQ'(1) << m_win;
        e_err     = 1'b1;
        m_ptr     = (m_win + 1) % NUM_REQ;
        m_wait    = 0;
        m_free_at = cyc + 1;
        m_drops++;
      end else if (ready) begin
        e_cmd   = m_msg | 16'h8000;
        e_grant = NUM_REQ'(1) << m_win;
        tgt     = bc ? '1 : (NUM_VP'(1) << dst);
        if (m_msg[7:4] == VP_COMMAND_START_MAIN_THREAD) m_run_next = m_run | tgt;
        else if (m_msg[7:4] == VP_COMMAND_STOP_MAIN_THREAD) m_run_next = m_run & ~tgt;
        else m_run_next = m_run;
        m_run_at  = cyc + 2;
        m_ptr     = (m_win + 1) % NUM_REQ;
        m_wait    = 0;
        m_free_at = cyc + 3;
        m_issues++;
      end
    end else if (cyc >= m_free_at && pend != '0) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        k = (m_ptr + i) % NUM_REQ;
        if (pend[k] && !m_wait) begin
          m_wait      = 1;
          m_win       = k;
          m_msg       = pend_msg[k];
          m_chk_start = cyc + 1;
        end
      end
    end
  endtask

  // Driver: one clock, compare, requester update, drive inputs, advance model
  task automatic run_cycle(input logic [NUM_VP-1:0] busy);
    @(negedge Clock);
    cyc++;
    if (m_run_at == cyc) begin
      m_run    = m_run_next;
      m_run_at = -1;
    end
    chk("cmd", oCpCommand, e_cmd);
    chk("grant", oGrant, e_grant);
    chk("req_err", oReqErr, e_err);
    chk("vp_running", oVpRunning, m_run);
    pend = pend & ~oGrant;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (stage[k] && !pend[k]) begin
        pend[k]     = 1'b1;
        pend_msg[k] = stage_msg[k];
      end
    end
    stage   = '0;
    iVpBusy = busy;
    drive();
    model_step();
  endtask

  task automatic do_reset(input int hold);
    @(negedge Clock);
    Reset = 1'b1;
    pend  = '0;
    stage = '0;
    drive();
    #1;
    chk("rst_cmd", oCpCommand, 0);
    chk("rst_grant", oGrant, 0);
    chk("rst_err", oReqErr, 0);
    chk("rst_running", oVpRunning, 0);
    chk("rst_state", oDbgState, 0);
`ifdef CP_SCHED_STATS_EN
    chk("rst_issue_cnt", oIssueCount, 0);
    chk("rst_drop_cnt", oDropCount, 0);
`endif
    repeat (hold) @(negedge Clock);
    Reset = 1'b0;
    model_reset();
    model_step();
  endtask

  initial begin
    int k;
    logic [3:0] op;
    logic [NUM_VP-1:0] busy;
    Reset   = 1'b1;
    iVpBusy = '0;
    pend    = '0;
    stage   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pend_msg[i]  = '0;
      stage_msg[i] = '0;
    end
    drive();
    do_reset(2);

    // Unicast START from requester 2 to VP 3
    post(2, mk_msg(0, 0, 3, VP_COMMAND_START_MAIN_THREAD, 4'h5));
    repeat (8) run_cycle('0);

    // All four requesters at once
    post(0, mk_msg(0, 0, 0, VP_COMMAND_START_MAIN_THREAD, 4'h1));
    post(1, mk_msg(1, 0, 1, VP_COMMAND_SET_ARG, 4'h2));
    post(2, mk_msg(0, 0, 2, VP_COMMAND_START_MAIN_THREAD, 4'h3));
    post(3, mk_msg(0, 0, 1, VP_COMMAND_START_MAIN_THREAD, 4'h4));
    repeat (22) run_cycle('0);

    // Broadcast STOP blocked by one busy VP for 10 cycles
    post(1, mk_msg(0, 1, 0, VP_COMMAND_STOP_MAIN_THREAD, 4'h0));
    repeat (10) run_cycle(4'b0010);
    repeat (6) run_cycle('0);

    // Unicast to a VP that stays busy: timeout drop
    post(0, mk_msg(0, 0, 1, VP_COMMAND_START_MAIN_THREAD, 4'h7));
    repeat (72) run_cycle(4'b0010);
    repeat (3) run_cycle('0);

    // Out-of-range destination alongside a valid request
    post(3, mk_msg(0, 0, 7, VP_COMMAND_START_MAIN_THREAD, 4'h9));
    post(0, mk_msg(0, 0, 2, VP_COMMAND_START_MAIN_THREAD, 4'hA));
    repeat (12) run_cycle('0);

    // Reset while a request waits in the check window
    post(1, mk_msg(0, 0, 0, VP_COMMAND_START_MAIN_THREAD, 4'hB));
    repeat (4) run_cycle(4'b0001);
    do_reset(1);
    repeat (6) run_cycle('0);

    // Randomized traffic with random backpressure
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        k = $urandom_range(0, NUM_REQ - 1);
        case ($urandom_range(0, 3))
          0, 1:    op = VP_COMMAND_START_MAIN_THREAD;
          2:       op = VP_COMMAND_STOP_MAIN_THREAD;
          default: op = 4'($urandom_range(0, 15));
        endcase
        if (!pend[k])
          post(k, mk_msg(1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0,
                         $urandom_range(0, 5), op, 4'($urandom_range(0, 15))));
      end
      for (int v = 0; v < NUM_VP; v++) busy[v] = ($urandom_range(0, 5) == 0);
      run_cycle(busy);
    end

    // Drain: every outstanding request must be granted within the budget
    repeat (100) run_cycle('0);
    chk("all_served", 32'(pend), 0);
`ifdef CP_SCHED_STATS_EN
    chk("issue_cnt", oIssueCount, 16'(m_issues));
    chk("drop_cnt", oDropCount, 16'(m_drops));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
